// File: rtl/mvm_uart_pkg.sv
// Shared UART definitions for the MVM system (RX and TX stages).
// Holds the receiver state enum, default framing constants and a parity helper.
package mvm_uart_pkg;

  localparam int DEF_CLOCKS_PER_PULSE = 2604;
  localparam int DEF_BITS_PER_WORD    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic logic even_bit(
    input logic [DEF_BITS_PER_WORD-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/mvm_uart_rx_if.sv
// Single-entry valid/ready byte stream from the UART RX stage
// to the MVM input loader.
interface mvm_uart_rx_if
  import mvm_uart_pkg::*;
#(
  parameter int W = DEF_BITS_PER_WORD
) ();

  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs.
// RST_VAL sets the value both flops take during reset.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mvm_uart_rx.sv
// UART receiver feeding the MVM input buffer: 8N1 frames, or 8E1 when
// MVM_UART_RX_PARITY_EN is defined; errors are reported as one-cycle pulses.
module mvm_uart_rx
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
  parameter int BITS_PER_WORD    = DEF_BITS_PER_WORD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  mvm_uart_rx_if.master m,
  output logic          frame_err,
  output logic          parity_err,
  output logic          overrun
);

  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int IW =
    (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;

  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [IW-1:0] LAST =
    IW'(BITS_PER_WORD - 1);

  logic rx_s;

  rx_state_t               state_q;
  rx_state_t               state_d;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           cnt_d;
  logic [IW-1:0]           idx_q;
  logic [IW-1:0]           idx_d;
  logic [BITS_PER_WORD-1:0] sh_q;
  logic [BITS_PER_WORD-1:0] sh_d;
  logic                    brk_q;
  logic                    brk_d;
  logic                    good;
  logic                    ferr;
`ifdef MVM_UART_RX_PARITY_EN
  logic                    perr_q;
  logic                    perr_d;
  logic                    perr_hit;
`endif

  sync_2ff #(
    .W       (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // next-state, bit timing and end-of-frame verdict
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    brk_d   = brk_q;
    good    = 1'b0;
    ferr    = 1'b0;
`ifdef MVM_UART_RX_PARITY_EN
    perr_d   = perr_q;
    perr_hit = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s) begin
          brk_d = 1'b0;
        end else if (!brk_q) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          idx_d = '0;
`ifdef MVM_UART_RX_PARITY_EN
          perr_d = 1'b0;
`endif
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d       = '0;
          sh_d[idx_q] = rx_s;
          idx_d       = idx_q + 1'b1;
          if (idx_q == LAST) begin
`ifdef MVM_UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef MVM_UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          perr_d  = (rx_s != (^sh_q));
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s) begin
            ferr  = 1'b1;
            brk_d = 1'b1;
`ifdef MVM_UART_RX_PARITY_EN
          end else if (perr_q) begin
            perr_hit = 1'b1;
`endif
          end else begin
            good = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and frame datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      brk_q   <= 1'b0;
`ifdef MVM_UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      brk_q   <= brk_d;
`ifdef MVM_UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // holding register and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      m.m_data  <= '0;
      m.m_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= good && m.m_valid && !m.m_ready;
      if (good && (!m.m_valid || m.m_ready)) begin
        m.m_data  <= sh_q;
        m.m_valid <= 1'b1;
      end else if (m.m_valid && m.m_ready) begin
        m.m_valid <= 1'b0;
      end
    end
  end

`ifdef MVM_UART_RX_PARITY_EN
  // parity error pulse aligned with the other verdicts
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_hit;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/mvm_uart_rx.md
# mvm_uart_rx

UART receiver stage that sits directly upstream of the matrix-vector multiplier's input buffer in the UART MVM system. It samples the serial `rx` pin, deserializes 8N1 frames (optionally 8E1), and presents each received byte on a single-entry valid/ready stream that the MVM input loader consumes. It also reports framing, parity and overrun errors as one-cycle pulses.

## Interface
- `CLOCKS_PER_PULSE`, default 2604 (50 MHz / 19200 baud): clock cycles per bit period. Must be ≥ 4.
- `BITS_PER_WORD`, default 8: data bits per frame, LSB first.

- `clk`  in  1  system clock. One clock domain; every flop is on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `rx`  in  1  serial input. Asynchronous to `clk`; idles high.
- `m_data`  out  BITS_PER_WORD  received byte. Valid only while `m_valid` is high.
- `m_valid`  out  1  holding register contains an unconsumed byte.
- `m_ready`  in  1  consumer accepts the byte.
- `frame_err`  out  1  one-cycle pulse: stop bit was sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Tied to 0 when parity is compiled out.
- `overrun`  out  1  one-cycle pulse: a good byte was dropped because the holding register was full.

## Operation
- `rx` passes through a 2-flop synchronizer, which always resets to 1. `rx_s` is the synchronizer output.
- Let H = CLOCKS_PER_PULSE/2 (integer floor). A single bit-period counter `cnt` and a bit index `idx` drive the state machine below.
- **IDLE**
  - On `rx_s == 0`: go to START and clear `cnt`.
- **START**
  - When `cnt == H-1`, resample `rx_s`.
  - If `rx_s == 1`, this is a false start: go back to IDLE with no error.
  - Otherwise go to DATA with `cnt = 0` and `idx = 0`.
- **DATA**
  - Every time `cnt == CLOCKS_PER_PULSE-1`, sample `rx_s` into shift register bit `idx` (LSB first) and increment `idx`.
  - After bit BITS_PER_WORD-1 is sampled, go to PARITY if it is compiled in, otherwise to STOP.
- **PARITY**
  - Sample the parity bit one period later.
  - A mismatch is latched internally.
- **STOP**
  - Sample the stop bit one period later, then always return to IDLE on the next cycle.
  - If the stop bit is 0: pulse `frame_err` and discard the byte.
  - Else if a parity mismatch was latched: pulse `parity_err` and discard the byte.
  - Otherwise the byte is "good" and is delivered to the holding register.
- **Holding register**
  - A good byte loads `m_data` and sets `m_valid` on the cycle after the stop sample.
  - A handshake (`m_valid && m_ready`) clears `m_valid` unless a good byte loads in the same cycle.
  - Good byte arriving while `m_valid=1` and `m_ready=0`: keep the old byte, drop the new one, pulse `overrun`.
  - Good byte arriving while `m_valid=1` and `m_ready=1`: load the new byte, `m_valid` stays 1, no overrun.
- **Back-to-back frames**: IDLE is re-entered at mid-stop-bit, so a start edge that follows immediately is detected correctly.
- **Break** (`rx` held low): produces `frame_err` once per frame, then waits in IDLE until `rx_s` returns to 1 before arming a new start.
- **Reset**, synchronous, mid-frame or otherwise:
  - State = IDLE; `cnt`, `idx` and the shift register are cleared.
  - `m_valid=0`, `m_data=0`, all error pulses 0, synchronizer set to 1.
  - Any partial frame is discarded.

## Timing
- t0 = the first edge at which IDLE sees `rx_s == 0`. This is 2–3 cycles after the `rx` pin falls.
- Start check: t0+H.
- Data bit i sampled at t0+H+(i+1)·CLOCKS_PER_PULSE.
- Stop bit sampled at t0+H+(BITS_PER_WORD+1)·CLOCKS_PER_PULSE. With parity enabled, add one more CLOCKS_PER_PULSE.
- `m_valid` or the error pulse is asserted 1 cycle after the stop sample.
- `m_data` is stable while `m_valid=1 && m_ready=0`.
- `m_valid` has no combinational dependence on `m_ready`.

## Configuration
- `MVM_UART_RX_PARITY_EN`
  - Defined: the frame is 8E1. An even-parity bit is expected between the last data bit and the stop bit; a mismatch discards the byte and pulses `parity_err`.
  - Undefined: the frame is 8N1. The PARITY state is absent and `parity_err` is constant 0.

## Structure
- Shared package `mvm_uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - default `CLOCKS_PER_PULSE` and `BITS_PER_WORD` constants, which are shared with the TX stage.
- One sub-module, `sync_2ff`: a generic 2-flop synchronizer with a reset value parameter, instantiated here with reset value 1.

## Test plan
All scenarios use CLOCKS_PER_PULSE=16 with a bit-accurate UART driver model.
- Send 0xA5 with `m_ready=1` → `m_data=0xA5`, `m_valid` high for exactly 1 cycle, asserted at t0+8+9·16+1; no error pulses.
- Send 0x3C then 0xC3 back-to-back with `m_ready=0`, then raise `m_ready` → `m_data` stays 0x3C; `overrun` pulses once at the second stop sample; a single handshake delivers 0x3C.
- Send a 4-cycle low glitch on `rx` → false start; no `m_valid`, no errors; the next frame (0x55) is received correctly.
- Send 0x81 with the stop bit forced to 0 → `frame_err` pulses once, `m_valid` stays 0; a following 0x7E is received.
- Assert `rst` for 1 cycle in the middle of the DATA state, then send 0x0F → no spurious byte from the aborted frame; 0x0F is received.
- With `MVM_UART_RX_PARITY_EN` defined: send 0x07 with correct parity bit 1 → byte received. Send 0x07 with parity bit 0 → `parity_err` pulses and no `m_valid`.
